// File: rtl/tdm_demultiplexer_if.sv
// Serial-link receive bus: stream bit in, four channel words plus status out.
interface tdm_demultiplexer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             serial_in;
  logic             bit_valid;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             valid0;
  logic             valid1;
  logic             valid2;
  logic             valid3;
  logic             locked;
  logic             frame_error;

  // Link side: drives the stream, observes the channel registers.
  modport master (
    output serial_in, bit_valid,
    input  out0, out1, out2, out3,
    input  valid0, valid1, valid2, valid3,
    input  locked, frame_error
  );

  // Demultiplexer side.
  modport slave (
    input  serial_in, bit_valid,
    output out0, out1, out2, out3,
    output valid0, valid1, valid2, valid3,
    output locked, frame_error
  );
endinterface

// File: rtl/tdm_demultiplexer.sv
// TDM receive demultiplexer: hunts for the sync word, then steers four
// slot words per frame into channel registers, re-checking sync every frame.
module tdm_demultiplexer #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5
) (
  input logic               clk,
  input logic               reset,
  tdm_demultiplexer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_RECEIVE = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_window;
  logic [CW-1:0]         r_count;
  logic [BW-1:0]         r_bit_cnt;
  logic [WIDTH-1:0]      r_word;
  logic [1:0]            r_slot;
  logic [3:0][WIDTH-1:0] r_out;
  logic [3:0]            r_valid;
  logic                  r_locked;
  logic                  r_frame_error;

  logic [WIDTH-1:0]      w_shift_win;
  logic [WIDTH-1:0]      w_shift_word;
  logic                  w_sync_hit;
  logic                  w_last_bit;
  logic                  w_check_ok;
  logic [3:0]            w_valid_next;
  logic                  w_locked_next;
  logic                  w_ferr_next;

  // Shifted views including the bit sampled on this edge.
  assign w_shift_win  = {r_window[WIDTH-2:0], bus.serial_in};
  assign w_shift_word = {r_word[WIDTH-2:0], bus.serial_in};
  assign w_sync_hit   = bus.bit_valid && (w_shift_win == SYNC_WORD)
                        && (r_count >= CW'(WIDTH - 1));
  assign w_last_bit   = bus.bit_valid && (r_bit_cnt == BW'(WIDTH - 1));
  assign w_check_ok   = (w_shift_word == SYNC_WORD);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HUNT;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HUNT:    if (w_sync_hit) w_state_next = S_RECEIVE;
      S_RECEIVE: if (w_last_bit && (r_slot == 2'd3)) w_state_next = S_CHECK;
      S_CHECK:   if (w_last_bit) w_state_next = w_check_ok ? S_RECEIVE : S_HUNT;
      default:   w_state_next = S_HUNT;
    endcase
  end

  // Next values of the registered strobes and lock flag.
  always_comb begin
    w_valid_next  = 4'b0000;
    w_ferr_next   = 1'b0;
    w_locked_next = r_locked;
    case (r_state)
      S_HUNT:    if (w_sync_hit) w_locked_next = 1'b1;
      S_RECEIVE: if (w_last_bit) w_valid_next[r_slot] = 1'b1;
      S_CHECK: begin
        if (w_last_bit && !w_check_ok) begin
          w_ferr_next   = 1'b1;
          w_locked_next = 1'b0;
        end
      end
      default: w_locked_next = 1'b0;
    endcase
  end

  // Output registers; strobes default low every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= '0;
      r_locked      <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_valid       <= w_valid_next;
      r_locked      <= w_locked_next;
      r_frame_error <= w_ferr_next;
    end
  end

  // Bit-level datapath: hunt window, word shifter, counters, channel registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_window  <= '0;
      r_count   <= '0;
      r_bit_cnt <= '0;
      r_word    <= '0;
      r_slot    <= '0;
      r_out     <= '0;
    end else if (bus.bit_valid) begin
      case (r_state)
        S_HUNT: begin
          r_window <= w_shift_win;
          if (r_count != CW'(WIDTH)) r_count <= r_count + CW'(1);
          if (w_sync_hit) begin
            r_bit_cnt <= '0;
            r_slot    <= '0;
          end
        end
        S_RECEIVE: begin
          r_word <= w_shift_word;
          if (w_last_bit) begin
            r_bit_cnt     <= '0;
            r_out[r_slot] <= w_shift_word;
            r_slot        <= r_slot + 2'd1;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        S_CHECK: begin
          r_word <= w_shift_word;
          if (w_last_bit) begin
            r_bit_cnt <= '0;
            r_slot    <= '0;
            if (!w_check_ok) begin
              r_window <= '0;
              r_count  <= '0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        default: begin
          r_bit_cnt <= '0;
          r_slot    <= '0;
        end
      endcase
    end
  end

  assign bus.out0        = r_out[0];
  assign bus.out1        = r_out[1];
  assign bus.out2        = r_out[2];
  assign bus.out3        = r_out[3];
  assign bus.valid0      = r_valid[0];
  assign bus.valid1      = r_valid[1];
  assign bus.valid2      = r_valid[2];
  assign bus.valid3      = r_valid[3];
  assign bus.locked      = r_locked;
  assign bus.frame_error = r_frame_error;

endmodule
